// File: rtl/char_buf_arbiter_if.sv
// Bus bundle for char_buf_arbiter: CPU write port, VGA read port, clear control and the memory port.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface char_buf_arbiter_if;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_busy;
  logic        vga_re;
  logic [11:0] vga_addr;
  logic        vga_valid;
  logic [7:0]  vga_data;
  logic        clear_req;
  logic        clear_busy;
  logic        overflow;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, vga_re, vga_addr, clear_req, mem_rdata,
    output cpu_busy, vga_valid, vga_data, clear_busy, overflow, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_we, cpu_addr, cpu_data, vga_re, vga_addr, clear_req, mem_rdata,
    input  cpu_busy, vga_valid, vga_data, clear_busy, overflow, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/char_buf_arbiter.sv
// Single-port character buffer arbiter: VGA reads beat the clear engine, which beats the CPU write queue.
// Define CHARBUF_CLEAR_EN to build the full-screen clear engine (IDLE/DRAIN/CLEAR FSM).
module char_buf_arbiter #(
  parameter int unsigned QDEPTH    = 4,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input logic clk,
  input logic reset,
  char_buf_arbiter_if.slave bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  logic [11:0]   qa_q [QDEPTH];
  logic [11:0]   qa_d [QDEPTH];
  logic [7:0]    qd_q [QDEPTH];
  logic [7:0]    qd_d [QDEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rd_pend_q, rd_pend_d;
  logic [7:0]    vga_data_q, vga_data_d;
  logic [11:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_we;

  logic          busy, q_empty, push, pop, rd_gnt;
  logic          pop_allowed, clr_gnt;
  logic [11:0]   clr_addr;

  assign busy    = (cnt_q == QFULL);
  assign q_empty = (cnt_q == '0);
  assign push    = bus.cpu_we & ~busy;
  assign rd_gnt  = bus.vga_re & ~reset;
  assign pop     = pop_allowed & ~rd_gnt & ~q_empty;

`ifdef CHARBUF_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t      state_q, state_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pop_allowed = 1'b0;
    clr_gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        pop_allowed = 1'b1;
        if (bus.clear_req) state_d = DRAIN;
      end
      DRAIN: begin
        pop_allowed = 1'b1;
        if (q_empty) state_d = CLEAR;
      end
      CLEAR: begin
        // Queue is frozen here so anything enqueued lands after the fill.
        if (!rd_gnt) begin
          clr_gnt = 1'b1;
          if (clr_cnt_q == 12'hFFF) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_addr       = clr_cnt_q;
  assign bus.clear_busy = (state_q != IDLE);
`else
  logic unused_clear;
  assign unused_clear   = &{1'b0, bus.clear_req, FILL_CHAR};
  assign pop_allowed    = 1'b1;
  assign clr_gnt        = 1'b0;
  assign clr_addr       = '0;
  assign bus.clear_busy = 1'b0;
`endif

  always_comb begin
    qa_d  = qa_q;
    qd_d  = qd_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      qa_d[wp_q] = bus.cpu_addr;
      qd_d[wp_q] = bus.cpu_data;
      wp_d       = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Memory port mux; address and data hold their last granted value when idle.
  always_comb begin
    mem_we      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_gnt) begin
      mem_addr_d = bus.vga_addr;
    end else if (clr_gnt) begin
      mem_we      = 1'b1;
      mem_addr_d  = clr_addr;
      mem_wdata_d = FILL_CHAR;
    end else if (pop) begin
      mem_we      = 1'b1;
      mem_addr_d  = qa_q[rp_q];
      mem_wdata_d = qd_q[rp_q];
    end
  end

  always_comb begin
    ovf_d      = ovf_q | (bus.cpu_we & busy);
    rd_pend_d  = rd_gnt;
    vga_data_d = rd_pend_q ? bus.mem_rdata : vga_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      vga_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rd_pend_q   <= rd_pend_d;
      vga_data_q  <= vga_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    qa_q <= qa_d;
    qd_q <= qd_d;
  end

  assign bus.cpu_busy  = busy;
  assign bus.overflow  = ovf_q;
  assign bus.vga_valid = rd_pend_q;
  assign bus.vga_data  = vga_data_d;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Directed bench for char_buf_arbiter with a 4096-byte synchronous memory model and a write log.
// The clear-engine scenarios are compiled when CHARBUF_CLEAR_EN is defined.
module tb_char_buf_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  char_buf_arbiter_if bus();
  char_buf_arbiter #(.QDEPTH(4), .FILL_CHAR(8'h20)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0]  tbmem [4096];
  logic [19:0] wlog [$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      tbmem[bus.mem_addr] <= bus.mem_wdata;
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
    end
    bus.mem_rdata <= tbmem[bus.mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    #1;
    n_cmp++; if (bus.cpu_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", bus.cpu_busy); end
    n_cmp++; if (bus.vga_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vga_valid got=%b exp=0", bus.vga_valid); end
    n_cmp++; if (bus.vga_data !== 8'h00) begin n_bad++; $display("FAIL rst_vga_data got=%h exp=00", bus.vga_data); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 12'h000) begin n_bad++; $display("FAIL rst_mem_addr got=%h exp=000", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_mem_wdata got=%h exp=00", bus.mem_wdata); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
    n_cmp++; if (bus.clear_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clear_busy got=%b exp=0", bus.clear_busy); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    step(); bus.cpu_we = 1'b1; bus.cpu_addr = 12'h123; bus.cpu_data = 8'h41; bus.vga_re = 1'b0;
    step(); bus.cpu_we = 1'b0; #1;
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_we got=%b exp=1", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 12'h123) begin n_bad++; $display("FAIL wr_addr got=%h exp=123", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 8'h41) begin n_bad++; $display("FAIL wr_data got=%h exp=41", bus.mem_wdata); end
    step(); #1;
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL idle_we got=%b exp=0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 12'h123) begin n_bad++; $display("FAIL idle_addr_hold got=%h exp=123", bus.mem_addr); end
    step(); bus.vga_re = 1'b1; bus.vga_addr = 12'h123; #1;
    n_cmp++; if (bus.mem_addr !== 12'h123 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_port got=%h/%b exp=123/0", bus.mem_addr, bus.mem_we); end
    step(); bus.vga_re = 1'b0; #1;
    n_cmp++; if (bus.vga_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid got=%b exp=1", bus.vga_valid); end
    n_cmp++; if (bus.vga_data !== 8'h41) begin n_bad++; $display("FAIL rd_data got=%h exp=41", bus.vga_data); end
    step(); #1;
    n_cmp++; if (bus.vga_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_drop got=%b exp=0", bus.vga_valid); end
    n_cmp++; if (bus.vga_data !== 8'h41) begin n_bad++; $display("FAIL rd_data_hold got=%h exp=41", bus.vga_data); end
  endtask

  task automatic test_vga_priority();
    int we_seen = 0;
    logic [11:0] ea;
    logic [7:0]  ed;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.vga_re = 1'b1; bus.vga_addr = 12'h000;
      bus.cpu_we = (i < 3); bus.cpu_addr = 12'h200 + 12'(i); bus.cpu_data = 8'hA0 + 8'(i);
      #1;
      if (bus.mem_we === 1'b1) we_seen++;
    end
    n_cmp++; if (we_seen !== 0) begin n_bad++; $display("FAIL prio_we_during_read got=%0d exp=0", we_seen); end
    for (int k = 0; k < 3; k++) begin
      step(); bus.vga_re = 1'b0; bus.cpu_we = 1'b0; #1;
      ea = 12'h200 + 12'(k);
      ed = 8'hA0 + 8'(k);
      n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea || bus.mem_wdata !== ed) begin
        n_bad++; $display("FAIL prio_drain%0d got=%b/%h/%h exp=1/%h/%h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea, ed);
      end
    end
    step(); #1;
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL prio_after_drain got=%b exp=0", bus.mem_we); end
  endtask

  task automatic test_overflow();
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      bus.vga_re = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 12'h300 + 12'(i); bus.cpu_data = 8'hB0 + 8'(i);
      #1;
      if (i == 3) begin
        n_cmp++; if (bus.cpu_busy !== 1'b0) begin n_bad++; $display("FAIL ovf_busy3 got=%b exp=0", bus.cpu_busy); end
      end
      if (i == 4) begin
        n_cmp++; if (bus.cpu_busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy4 got=%b exp=1", bus.cpu_busy); end
      end
    end
    step(); bus.cpu_we = 1'b0; bus.vga_re = 1'b0; #1;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    n_cmp++; if (bus.cpu_busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy_registered got=%b exp=1", bus.cpu_busy); end
    repeat (6) step();
    #1;
    n_cmp++; if (wlog.size() !== 4) begin n_bad++; $display("FAIL ovf_drain_count got=%0d exp=4", wlog.size()); end
    if (wlog.size() == 4) begin
      n_cmp++; if (wlog[3] !== {12'h303, 8'hB3}) begin n_bad++; $display("FAIL ovf_last_entry got=%h exp=303b3", wlog[3]); end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    n_cmp++; if (bus.cpu_busy !== 1'b0) begin n_bad++; $display("FAIL ovf_busy_empty got=%b exp=0", bus.cpu_busy); end
    reset = 1'b1; #1;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_reset got=%b exp=0", bus.overflow); end
    step(); reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      step(); bus.vga_re = 1'b0; bus.cpu_we = 1'b1;
      bus.cpu_addr = 12'h400 + 12'(i); bus.cpu_data = 8'hC0 + 8'(i);
    end
    step(); bus.cpu_we = 1'b0;
    repeat (4) step();
    #1;
    n_cmp++; if (wlog.size() !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", wlog.size()); end
    if (wlog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        e = {12'h400 + 12'(i), 8'hC0 + 8'(i)};
        n_cmp++; if (wlog[i] !== e) begin n_bad++; $display("FAIL b2b_order%0d got=%h exp=%h", i, wlog[i], e); end
      end
    end
  endtask

`ifdef CHARBUF_CLEAR_EN
  task automatic test_clear();
    int cyc = 0;
    int badc = 0;
    bit late = 1'b0;
    wlog.delete();
    for (int i = 0; i < 2; i++) begin
      step(); bus.vga_re = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 12'h700 + 12'(i); bus.cpu_data = 8'hD0 + 8'(i);
    end
    step(); bus.cpu_we = 1'b0; bus.vga_re = 1'b0; bus.clear_req = 1'b1;
    step(); bus.clear_req = 1'b0; #1;
    n_cmp++; if (bus.clear_busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy_rise got=%b exp=1", bus.clear_busy); end
    while (bus.clear_busy === 1'b1 && cyc < 6000) begin
      bus.cpu_we = 1'b0;
      if (!late && bus.mem_we === 1'b1 && bus.mem_addr == 12'h010) begin
        bus.cpu_we = 1'b1; bus.cpu_addr = 12'h005; bus.cpu_data = 8'h77; late = 1'b1;
      end
      step(); #1;
      cyc++;
    end
    bus.cpu_we = 1'b0;
    n_cmp++; if (cyc >= 6000) begin n_bad++; $display("FAIL clr_timeout got=%0d cycles exp=<6000", cyc); end
    repeat (4) step();
    #1;
    n_cmp++; if (wlog.size() !== 4099) begin n_bad++; $display("FAIL clr_count got=%0d exp=4099", wlog.size()); end
    if (wlog.size() == 4099) begin
      n_cmp++; if (wlog[0] !== {12'h700, 8'hD0} || wlog[1] !== {12'h701, 8'hD1}) begin
        n_bad++; $display("FAIL clr_drain got=%h,%h exp=700d0,701d1", wlog[0], wlog[1]);
      end
      for (int i = 0; i < 4096; i++) if (wlog[i + 2] !== {12'(i), 8'h20}) badc++;
      n_cmp++; if (badc !== 0) begin n_bad++; $display("FAIL clr_fill got=%0d bad entries exp=0", badc); end
      n_cmp++; if (wlog[4098] !== {12'h005, 8'h77}) begin n_bad++; $display("FAIL clr_late_write got=%h exp=00577", wlog[4098]); end
    end
    n_cmp++; if (tbmem[12'h005] !== 8'h77) begin n_bad++; $display("FAIL clr_mem005 got=%h exp=77", tbmem[12'h005]); end
    n_cmp++; if (bus.clear_busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_fall got=%b exp=0", bus.clear_busy); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc = 0;
    wlog.delete();
    step(); bus.clear_req = 1'b1;
    step(); bus.clear_req = 1'b0; #1;
    while (!(bus.mem_we === 1'b1 && bus.mem_addr == 12'h800) && cyc < 3000) begin
      step(); #1;
      cyc++;
    end
    n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL mid_timeout got=%0d cycles exp=<3000", cyc); end
    reset = 1'b1; #1;
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_we got=%b exp=0", bus.mem_we); end
    n_cmp++; if (bus.clear_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", bus.clear_busy); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL mid_overflow got=%b exp=0", bus.overflow); end
    n_cmp++; if (wlog.size() !== 2048) begin n_bad++; $display("FAIL mid_prefix got=%0d exp=2048", wlog.size()); end
    wlog.delete();
    repeat (2) step();
    reset = 1'b0;
    repeat (20) step();
    n_cmp++; if (wlog.size() !== 0) begin n_bad++; $display("FAIL mid_no_writes got=%0d exp=0", wlog.size()); end
  endtask
`else
  task automatic test_no_clear();
    wlog.delete();
    step(); bus.clear_req = 1'b1; #1;
    n_cmp++; if (bus.clear_busy !== 1'b0) begin n_bad++; $display("FAIL nc_busy_pulse got=%b exp=0", bus.clear_busy); end
    step(); bus.clear_req = 1'b0;
    repeat (10) step();
    n_cmp++; if (bus.clear_busy !== 1'b0) begin n_bad++; $display("FAIL nc_busy_after got=%b exp=0", bus.clear_busy); end
    n_cmp++; if (wlog.size() !== 0) begin n_bad++; $display("FAIL nc_writes got=%0d exp=0", wlog.size()); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) tbmem[i] = 8'h00;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.vga_re = 1'b0; bus.vga_addr = '0; bus.clear_req = 1'b0;
    test_reset();
    test_write_read();
    test_vga_priority();
    test_overflow();
    test_back_to_back();
`ifdef CHARBUF_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_no_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
